// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: diff = minuend - subtrahend - borrow_in, CHUNK_WID bits per clock.
// Define SUB_FLAGS_EN to add the registered zero and overflow flag outputs.
module chunked_subtractor #(
  parameter int DATA_WID  = 32,
  parameter int CHUNK_WID = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] minuend,
  input  logic [DATA_WID-1:0] subtrahend,
  input  logic                borrow_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] diff,
`ifdef SUB_FLAGS_EN
  output logic                zero,
  output logic                overflow,
`endif
  output logic                borrow_out
);

  localparam int NUM_CHUNKS = DATA_WID / CHUNK_WID;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
  localparam int MSB        = DATA_WID - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WID-1:0]   a_q, b_q, diff_q, diff_nxt;
  logic [IDX_W-1:0]      idx;
  logic                  borrow_reg, borrow_out_q, chunk_bout;
  logic [CHUNK_WID-1:0]  chunk_diff;

  // Subtraction as A + ~B + ~borrow; the borrow out is the inverted carry.
  function automatic logic [CHUNK_WID:0] chunk_sub(input logic [CHUNK_WID-1:0] a,
                                                   input logic [CHUNK_WID-1:0] b,
                                                   input logic bin);
    logic [CHUNK_WID:0] sum;
    sum = {1'b0, a} + {1'b0, ~b} + {{CHUNK_WID{1'b0}}, ~bin};
    return {~sum[CHUNK_WID], sum[CHUNK_WID-1:0]};
  endfunction

  always_comb begin
    {chunk_bout, chunk_diff} = chunk_sub(a_q[int'(idx)*CHUNK_WID +: CHUNK_WID],
                                         b_q[int'(idx)*CHUNK_WID +: CHUNK_WID],
                                         borrow_reg);
    diff_nxt = diff_q;
    diff_nxt[int'(idx)*CHUNK_WID +: CHUNK_WID] = chunk_diff;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      borrow_reg   <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero         <= 1'b0;
      overflow     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= minuend;
            b_q        <= subtrahend;
            borrow_reg <= borrow_in;
            idx        <= '0;
          end
        end
        RUN: begin
          diff_q     <= diff_nxt;
          borrow_reg <= chunk_bout;
          idx        <= idx + 1'b1;
          // Last chunk: publish the final borrow and flags as DONE is entered.
          if (idx == LAST_IDX) begin
            idx          <= '0;
            borrow_out_q <= chunk_bout;
`ifdef SUB_FLAGS_EN
            zero         <= (diff_nxt == '0);
            overflow     <= (a_q[MSB] != b_q[MSB]) && (diff_nxt[MSB] != a_q[MSB]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench for chunked_subtractor: directed and random operations against
// a plain-arithmetic reference, plus backpressure and mid-operation reset.
module tb_chunked_subtractor;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NC = DW / CW;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, borrow_in, out_valid, out_ready, borrow_out;
  logic [DW-1:0] minuend, subtrahend, diff;
`ifdef SUB_FLAGS_EN
  logic          zero, overflow;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunked_subtractor #(.DATA_WID(DW), .CHUNK_WID(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .minuend(minuend), .subtrahend(subtrahend), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
`ifdef SUB_FLAGS_EN
    .zero(zero), .overflow(overflow),
`endif
    .borrow_out(borrow_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    in_valid   = 1'($urandom);
    minuend    = $urandom;
    subtrahend = $urandom;
    borrow_in  = 1'($urandom);
  endtask

  // One full operation; hold = cycles of out_ready=0 after the result appears.
  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bin,
                       input int hold);
    logic [DW:0]   full;
    logic [DW-1:0] de;
    logic          be;
    int            cnt;
    full = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, bin};
    de   = full[DW-1:0];
    be   = full[DW];
    cnt  = 0;
    while (!in_ready && cnt < 20) begin tick(); cnt++; end
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; minuend = a; subtrahend = b; borrow_in = bin;
    out_ready = (hold == 0);
    tick();
    check("accept_in_ready", in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      scramble_inputs();
      tick();
      cnt++;
    end
    check("latency", cnt, NC);
    check("diff", diff, de);
    check("borrow_out", borrow_out, be);
    check("done_in_ready", in_ready, 0);
`ifdef SUB_FLAGS_EN
    check("zero", zero, (de == '0));
    check("overflow", overflow, (a[DW-1] != b[DW-1]) && (de[DW-1] != a[DW-1]));
`endif
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      scramble_inputs();
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_diff", diff, de);
      check("bp_borrow", borrow_out, be);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("hs_diff_hold", diff, de);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    minuend = '0; subtrahend = '0; borrow_in = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
`ifdef SUB_FLAGS_EN
    check("rst_zero", zero, 0);
    check("rst_overflow", overflow, 0);
`endif
    rst = 1'b0;
    tick();

    do_op(32'h0000_000A, 32'h0000_0003, 1'b0, 0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    do_op(32'h0001_0000, 32'h0000_0001, 1'b1, 10);

    // Reset during RUN while chunk 2 would be computed.
    in_valid = 1'b1; minuend = 32'hDEAD_BEEF; subtrahend = 32'h0123_4567; borrow_in = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_completion", seen, 0);
    out_ready = 1'b0;

    for (int n = 0; n < 24; n++)
      do_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
